// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one 1R1W synchronous SRAM between two readers and two writers.
// Read data is captured into a credit-protected response FIFO tagged with the requester ID.
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 12,
    parameter int RESP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd0_req,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    output logic                  rd0_gnt,
    input  logic                  rd1_req,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic                  rd1_gnt,
    input  logic                  wr0_req,
    input  logic [ADDR_WIDTH-1:0] wr0_addr,
    input  logic [DATA_WIDTH-1:0] wr0_data,
    output logic                  wr0_gnt,
    input  logic                  wr1_req,
    input  logic [ADDR_WIDTH-1:0] wr1_addr,
    input  logic [DATA_WIDTH-1:0] wr1_data,
    output logic                  wr1_gnt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  sram_re,
    output logic [ADDR_WIDTH-1:0] sram_radr,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_wadr,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH) + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);

    logic                  wrPtr_q, wrPtr_d;
    logic                  rdPtr_q, rdPtr_d;
    logic                  inflight_q, inflightId_q;
    logic [PW-1:0]         head_q, tail_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         occupancy;
    logic [DATA_WIDTH-1:0] fifoData_q [RESP_DEPTH];
    logic                  fifoId_q   [RESP_DEPTH];

    logic                  wrPick1, rdPick1;
    logic                  rdHazard, creditOk, rdIssue;
    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] rdAddr;

    always_comb begin
        wrPick1   = wr1_req & (~wr0_req | wrPtr_q);
        wr0_gnt   = ~rst & wr0_req & ~wrPick1;
        wr1_gnt   = ~rst & wrPick1;
        sram_we   = wr0_gnt | wr1_gnt;
        sram_wadr = wrPick1 ? wr1_addr : wr0_addr;
        sram_d    = wrPick1 ? wr1_data : wr0_data;
        wrPtr_d   = (wr0_req & wr1_req) ? ~wrPtr_q : wrPtr_q;
    end

    always_comb begin
        rsp_valid = ~rst & (count_q != '0);
        pop       = rsp_valid & rsp_ready;
        push      = inflight_q;
        rsp_id    = rsp_valid ? fifoId_q[head_q] : 1'b0;
        rsp_data  = rsp_valid ? fifoData_q[head_q] : '0;
    end

    // A read colliding with this cycle's write is held back so it sees the new data next cycle.
    always_comb begin
        rdPick1   = rd1_req & (~rd0_req | rdPtr_q);
        rdAddr    = rdPick1 ? rd1_addr : rd0_addr;
        rdHazard  = sram_we & (rdAddr == sram_wadr);
        occupancy = count_q + CW'(inflight_q) - CW'(pop);
        creditOk  = occupancy < DEPTH_C;
        rdIssue   = ~rst & (rd0_req | rd1_req) & ~rdHazard & creditOk;
        rd0_gnt   = rdIssue & ~rdPick1;
        rd1_gnt   = rdIssue & rdPick1;
        sram_re   = rdIssue;
        sram_radr = rdAddr;
        rdPtr_d   = (rdIssue & rd0_req & rd1_req) ? ~rdPtr_q : rdPtr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q      <= 1'b0;
            rdPtr_q      <= 1'b0;
            inflight_q   <= 1'b0;
            inflightId_q <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            inflight_q   <= rdIssue;
            inflightId_q <= rdPick1;
            if (push) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // sram_q is only valid the cycle after sram_re, so it is captured right then.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifoData_q[tail_q] <= sram_q;
            fifoId_q[tail_q]   <= inflightId_q;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed plus randomized bench for sram_port_arbiter, with a behavioural SRAM
// and a queue-based reference model of arbitration and response ordering.
module tb_sram_port_arbiter;

    localparam int DW    = 128;
    localparam int AW    = 12;
    localparam int DEPTH = 2;
    localparam logic [DW-1:0] DATA_A5 = {16{8'hA5}};
    localparam logic [DW-1:0] DATA_10 = {4{32'h1010_CAFE}};
    localparam logic [DW-1:0] DATA_20 = {4{32'h2020_BEEF}};

    logic          clk;
    logic          rst;
    logic          rd0_req, rd1_req, wr0_req, wr1_req;
    logic [AW-1:0] rd0_addr, rd1_addr, wr0_addr, wr1_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [DW-1:0] rsp_data;
    logic          sram_re, sram_we;
    logic [AW-1:0] sram_radr, sram_wadr;
    logic [DW-1:0] sram_d, sram_q;

    int checks = 0;
    int errors = 0;

    sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt),
        .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt),
        .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
        .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .sram_re(sram_re), .sram_radr(sram_radr), .sram_we(sram_we),
        .sram_wadr(sram_wadr), .sram_d(sram_d), .sram_q(sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1R1W SRAM: read data lives for exactly one cycle, garbage otherwise.
    logic [DW-1:0] sramMem [4096];
    logic [DW-1:0] sramQReg;
    assign sram_q = sramQReg;
    initial begin
        for (int i = 0; i < 4096; i++) sramMem[i] = '0;
    end
    always @(posedge clk) begin
        if (sram_we) sramMem[sram_wadr] <= sram_d;
        if (sram_re) sramQReg <= sramMem[sram_radr];
        else         sramQReg <= {$urandom, $urandom, $urandom, $urandom};
    end

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] refMem [int];
    rsp_t          respQ [$];
    bit            pendValid = 0;
    rsp_t          pendRsp;
    int            wrTurn = 0;
    int            rdTurn = 0;
    logic          expRd0, expRd1, expWr0, expWr1;

    task automatic checkVal(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] rq,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [AW-1:0] w0a, input logic [AW-1:0] w1a,
                                 input logic [DW-1:0] w0d, input logic [DW-1:0] w1d,
                                 input logic rdy);
        @(posedge clk);
        #1;
        rst       = r;
        rd0_req   = rq[3];
        rd1_req   = rq[2];
        wr0_req   = rq[1];
        wr1_req   = rq[0];
        rd0_addr  = a0;
        rd1_addr  = a1;
        wr0_addr  = w0a;
        wr1_addr  = w1a;
        wr0_data  = w0d;
        wr1_data  = w1d;
        rsp_ready = rdy;
        @(negedge clk);
    endtask

    // Reference model: evaluates one cycle from the arbitration rules, compares, then advances.
    task automatic checkOutput();
        int            wrWin, rdWin, occ;
        logic [AW-1:0] wrA, rdA;
        logic [DW-1:0] wrD;
        bit            popNow, headValid;
        rsp_t          newRsp;
        if (rst) begin
            {expRd0, expRd1, expWr0, expWr1} = 4'b0000;
            checkVal("rst_gnts", {rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt}, '0);
            checkVal("rst_sram_en", {sram_re, sram_we}, '0);
            checkVal("rst_rsp", {rsp_valid, rsp_id}, '0);
            checkVal("rst_rsp_data", rsp_data, '0);
            respQ.delete();
            pendValid = 0;
            wrTurn = 0;
            rdTurn = 0;
            return;
        end
        wrWin = -1;
        if (wr0_req && wr1_req) begin
            wrWin  = wrTurn;
            wrTurn = 1 - wrTurn;
        end else if (wr0_req) wrWin = 0;
        else if (wr1_req) wrWin = 1;
        wrA = (wrWin == 1) ? wr1_addr : wr0_addr;
        wrD = (wrWin == 1) ? wr1_data : wr0_data;

        rdWin = -1;
        if (rd0_req && rd1_req) rdWin = rdTurn;
        else if (rd0_req) rdWin = 0;
        else if (rd1_req) rdWin = 1;
        rdA = (rdWin == 1) ? rd1_addr : rd0_addr;
        headValid = respQ.size() > 0;
        popNow    = headValid && rsp_ready;
        occ       = respQ.size() + (pendValid ? 1 : 0) - (popNow ? 1 : 0);
        if (rdWin >= 0 && (occ >= DEPTH || (wrWin >= 0 && rdA == wrA))) rdWin = -1;
        if (rdWin >= 0 && rd0_req && rd1_req) rdTurn = 1 - rdTurn;

        expRd0 = (rdWin == 0);
        expRd1 = (rdWin == 1);
        expWr0 = (wrWin == 0);
        expWr1 = (wrWin == 1);
        checkVal("gnts", {rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt}, {expRd0, expRd1, expWr0, expWr1});
        checkVal("sram_re", sram_re, rdWin >= 0);
        checkVal("sram_we", sram_we, wrWin >= 0);
        if (rdWin >= 0) checkVal("sram_radr", sram_radr, rdA);
        if (wrWin >= 0) begin
            checkVal("sram_wadr", sram_wadr, wrA);
            checkVal("sram_d", sram_d, wrD);
        end
        checkVal("rsp_valid", rsp_valid, headValid);
        checkVal("rsp_id", rsp_id, headValid ? respQ[0].id : 1'b0);
        checkVal("rsp_data", rsp_data, headValid ? respQ[0].data : '0);

        newRsp.id   = (rdWin == 1);
        newRsp.data = refMem.exists(int'(rdA)) ? refMem[int'(rdA)] : '0;
        if (wrWin >= 0) refMem[int'(wrA)] = wrD;
        if (popNow) void'(respQ.pop_front());
        if (pendValid) respQ.push_back(pendRsp);
        pendValid = (rdWin >= 0);
        pendRsp   = newRsp;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 4'b0000, '0, '0, '0, '0, '0, '0, rdy);
            checkOutput();
        end
    endtask

    logic          rReq [2];
    logic          wReq [2];
    logic [AW-1:0] rAddr [2];
    logic [AW-1:0] wAddr [2];
    logic [DW-1:0] wData [2];
    logic          bpExp [4];

    initial begin
        rst = 1'b1;
        {rd0_req, rd1_req, wr0_req, wr1_req} = 4'b0000;
        {rd0_addr, rd1_addr, wr0_addr, wr1_addr} = '0;
        wr0_data = '0;
        wr1_data = '0;
        rsp_ready = 1'b1;

        $display("[TB] reset with all requests high");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 4'b1111, 12'h010, 12'h020, 12'h030, 12'h040, DATA_10, DATA_20, 1'b1);
            checkOutput();
            checkVal("reset_no_gnt", {rd0_gnt, rd1_gnt, wr0_gnt, wr1_gnt}, '0);
        end
        applyStimulus(1'b0, 4'b1111, 12'h010, 12'h020, 12'h030, 12'h040, DATA_10, DATA_20, 1'b1);
        checkOutput();
        checkVal("post_reset_rd0_gnt", rd0_gnt, 1'b1);
        checkVal("post_reset_wr0_gnt", wr0_gnt, 1'b1);
        idle(4, 1'b1);

        $display("[TB] write then read");
        applyStimulus(1'b0, 4'b0010, '0, '0, 12'h005, '0, DATA_A5, '0, 1'b1);
        checkOutput();
        applyStimulus(1'b0, 4'b0100, '0, 12'h005, '0, '0, '0, '0, 1'b1);
        checkOutput();
        checkVal("wtr_rd1_gnt", rd1_gnt, 1'b1);
        idle(1, 1'b1);
        checkVal("wtr_not_early", rsp_valid, 1'b0);
        idle(1, 1'b1);
        checkVal("wtr_rsp_valid", rsp_valid, 1'b1);
        checkVal("wtr_rsp_id", rsp_id, 1'b1);
        checkVal("wtr_rsp_data", rsp_data, DATA_A5);
        idle(2, 1'b1);

        $display("[TB] round robin");
        applyStimulus(1'b0, 4'b0010, '0, '0, 12'h010, '0, DATA_10, '0, 1'b1);
        checkOutput();
        applyStimulus(1'b0, 4'b0010, '0, '0, 12'h020, '0, DATA_20, '0, 1'b1);
        checkOutput();
        applyStimulus(1'b1, 4'b0000, '0, '0, '0, '0, '0, '0, 1'b1);
        checkOutput();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 4'b1100, 12'h010, 12'h020, '0, '0, '0, '0, 1'b1);
            checkOutput();
            checkVal("rr_gnt", {rd0_gnt, rd1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i >= 2) begin
                checkVal("rr_rsp_id", rsp_id, (i % 2 == 1));
                checkVal("rr_rsp_data", rsp_data, (i % 2 == 0) ? DATA_10 : DATA_20);
            end
        end
        idle(4, 1'b1);

        $display("[TB] read/write hazard");
        applyStimulus(1'b0, 4'b1001, 12'h100, '0, '0, 12'h100, '0, 128'h1, 1'b1);
        checkOutput();
        checkVal("hz_wr1_gnt", wr1_gnt, 1'b1);
        checkVal("hz_rd0_blocked", rd0_gnt, 1'b0);
        applyStimulus(1'b0, 4'b1000, 12'h100, '0, '0, '0, '0, '0, 1'b1);
        checkOutput();
        checkVal("hz_rd0_gnt", rd0_gnt, 1'b1);
        idle(2, 1'b1);
        checkVal("hz_rsp_data", rsp_data, 128'h1);
        checkVal("hz_rsp_id", rsp_id, 1'b0);
        idle(2, 1'b1);

        $display("[TB] backpressure");
        bpExp = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'b1000, 12'h020, '0, '0, '0, '0, '0, 1'b0);
            checkOutput();
            checkVal("bp_rd0_gnt", rd0_gnt, bpExp[i]);
        end
        checkVal("bp_held_valid", rsp_valid, 1'b1);
        applyStimulus(1'b0, 4'b1000, 12'h020, '0, '0, '0, '0, '0, 1'b1);
        checkOutput();
        checkVal("bp_release_gnt", rd0_gnt, 1'b1);
        idle(5, 1'b1);

        $display("[TB] reset mid-flight");
        applyStimulus(1'b0, 4'b1000, 12'h010, '0, '0, '0, '0, '0, 1'b1);
        checkOutput();
        checkVal("mf_rd0_gnt", rd0_gnt, 1'b1);
        applyStimulus(1'b1, 4'b0000, '0, '0, '0, '0, '0, '0, 1'b1);
        checkOutput();
        for (int i = 0; i < 4; i++) begin
            idle(1, 1'b1);
            checkVal("mf_no_rsp", rsp_valid, 1'b0);
        end

        $display("[TB] randomized traffic");
        for (int k = 0; k < 2; k++) begin
            rReq[k] = 1'b0;
            wReq[k] = 1'b0;
        end
        {expRd0, expRd1, expWr0, expWr1} = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            if (!rReq[0] || expRd0) begin
                rReq[0] = ($urandom_range(0, 2) != 0);
                rAddr[0] = AW'($urandom_range(0, 7));
            end
            if (!rReq[1] || expRd1) begin
                rReq[1] = ($urandom_range(0, 2) != 0);
                rAddr[1] = AW'($urandom_range(0, 7));
            end
            if (!wReq[0] || expWr0) begin
                wReq[0] = ($urandom_range(0, 1) != 0);
                wAddr[0] = AW'($urandom_range(0, 7));
                wData[0] = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!wReq[1] || expWr1) begin
                wReq[1] = ($urandom_range(0, 1) != 0);
                wAddr[1] = AW'($urandom_range(0, 7));
                wData[1] = {$urandom, $urandom, $urandom, $urandom};
            end
            applyStimulus(1'b0, {rReq[0], rReq[1], wReq[0], wReq[1]}, rAddr[0], rAddr[1],
                          wAddr[0], wAddr[1], wData[0], wData[1], ($urandom_range(0, 3) != 0));
            checkOutput();
        end
        idle(4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
